// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU.
// Opcode encoding, FSM states, legal-opcode bound.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_SLTU = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_NOR  = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_SLT  = 4'd11,
        OP_MUL  = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd12;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle of the ALU.
// master = register-read/writeback side, slave = ALU.
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] read1;
    logic [WIDTH-1:0] read2;
    logic [3:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             err;

    modport master (
        output in_valid, read1, read2, control, out_ready,
        input  in_ready, out_valid, result,
        input  zero, negative, carry, overflow, err
    );

    modport slave (
        input  in_valid, read1, read2, control, out_ready,
        output in_ready, out_valid, result,
        output zero, negative, carry, overflow, err
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done is high during the last iteration; product is final after it.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    assign busy    = run;
    assign done    = run && (cnt == LAST);
    assign product = acc;

    // Load operands on start, then add-and-shift until the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops plus iterative MUL,
// registered result/flags behind valid/ready handshakes.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    mul_state_t state;
    mul_state_t state_nx;

    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;

    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_e;

    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             neg_q;
    logic             carry_q;
    logic             ovf_q;
    logic             err_q;
    logic             valid_q;

    assign a  = bus.read1;
    assign b  = bus.read2;
    assign sh = bus.read2[SHW-1:0];

    assign bus.in_ready = (state == ST_IDLE)
                        && (!valid_q || bus.out_ready)
                        && !reset;
    assign accept    = bus.in_valid && bus.in_ready;
    assign is_mul    = (bus.control == OP_MUL);
    assign mul_start = accept && is_mul;

    assign bus.out_valid = valid_q;
    assign bus.result    = res_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.err       = err_q;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // Single-cycle datapath: result plus carry/overflow/illegal.
    always_comb begin
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} - {1'b0, b};
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_e    = 1'b0;
        case (bus.control)
            OP_ADD: begin
                sc_res = sum_add[WIDTH-1:0];
                sc_c   = sum_add[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1])
                       && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sum_sub[WIDTH-1:0];
                sc_c   = sum_sub[WIDTH];
                sc_v   = (a[WIDTH-1] != b[WIDTH-1])
                       && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOT:  sc_res = ~a;
            OP_NOR:  sc_res = ~(a | b);
            OP_SLL:  sc_res = a << sh;
            OP_SRL:  sc_res = a >> sh;
            OP_SRA:  sc_res = $signed(a) >>> sh;
            OP_SLT: begin
                sc_res = {{(WIDTH-1){1'b0}},
                          $signed(a) < $signed(b)};
            end
            OP_MUL:  sc_res = '0;
            default: sc_e = (bus.control > OP_LAST_LEGAL);
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: MUL runs the multiplier, DONE loads its result.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (mul_start) state_nx = ST_MUL;
            ST_MUL:  if (mul_done)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output registers: load on single-cycle accept or MUL done,
    // hold while stalled, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (accept && !is_mul) begin
            res_q   <= sc_res;
            zero_q  <= (sc_res == '0);
            neg_q   <= sc_res[WIDTH-1];
            carry_q <= sc_c;
            ovf_q   <= sc_v;
            err_q   <= sc_e;
            valid_q <= 1'b1;
        end else if (state == ST_DONE) begin
            res_q   <= product[WIDTH-1:0];
            zero_q  <= (product[WIDTH-1:0] == '0);
            neg_q   <= product[WIDTH-1];
            carry_q <= |product[2*WIDTH-1:WIDTH];
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = mul_busy;

endmodule
